// File: rtl/offchip_lane_link.sv
// Off-chip lane link: words are split into LANES beats, carried through a credit-controlled
// beat FIFO and reassembled on the far side, with an optional byte-interleave lane mapping.

module offchip_lane_link_chk #(
    parameter int DEPTH = 8,
    parameter int CW    = 4
) (
    input logic          clk,
    input logic          rst,
    input logic          wr_en,
    input logic          pop,
    input logic [CW-1:0] fifo_count,
    input logic [CW-1:0] credits
);
    // Credit reservation must make a write into a full FIFO impossible
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(wr_en && !pop && (fifo_count == CW'(DEPTH))));

    a_credit_cap: assert property (@(posedge clk) disable iff (rst)
        (credits <= CW'(DEPTH)));
endmodule

module offchip_lane_link #(
    parameter int DATA_W     = 64,
    parameter int LANES      = 2,
    parameter int DEPTH      = 8,
    parameter int CREDIT_LAT = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         in_mode,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W/LANES-1:0]      link_beat,
    output logic                         link_valid,
    output logic [$clog2(DEPTH+1)-1:0]   credits,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);
    localparam int BEAT_W = DATA_W / LANES;
    localparam int BB     = BEAT_W / 8;
    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = $clog2(DEPTH + 1);
    localparam int KW     = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [KW-1:0] K_LAST  = KW'(LANES - 1);
    localparam logic [KW-1:0] K_ZERO  = {KW{1'b0}};
    localparam logic [CW-1:0] C_LANES = CW'(LANES);

    typedef enum logic {W_IDLE = 1'b0, W_SPLIT = 1'b1} w_state_t;
    typedef enum logic {R_COLLECT = 1'b0, R_HOLD = 1'b1} r_state_t;

    function automatic logic [BEAT_W-1:0] map_beat(input logic [DATA_W-1:0] word,
                                                   input logic mode, input int k);
        logic [BEAT_W-1:0] beat;
        int src;
        beat = {BEAT_W{1'b0}};
        for (int j = 0; j < BB; j++) begin
            src = mode ? (j * LANES + k) : (k * BB + j);
            beat[8*j +: 8] = word[8*src +: 8];
        end
        return beat;
    endfunction

    // Inverse of map_beat: drops the bytes of beat k back into their word positions
    function automatic logic [DATA_W-1:0] place_beat(input logic [DATA_W-1:0] acc,
                                                     input logic [BEAT_W-1:0] beat,
                                                     input logic mode, input int k);
        logic [DATA_W-1:0] word;
        int dst;
        word = acc;
        for (int j = 0; j < BB; j++) begin
            dst = mode ? (j * LANES + k) : (k * BB + j);
            word[8*dst +: 8] = beat[8*j +: 8];
        end
        return word;
    endfunction

    w_state_t          w_state_r, w_state_s;
    logic [KW-1:0]     k_r, k_s;
    logic [DATA_W-1:0] word_r;
    logic              mode_r;
    logic              last_beat_s, in_ready_s, accept_s, wr_en_s;
    logic [BEAT_W-1:0] link_beat_s;

    logic [CW-1:0]     credits_r, credits_s;
    logic              ret_s;

    logic [BEAT_W:0]   mem_r [DEPTH];
    logic [AW:0]       wptr_r, rptr_r, count_s;
    logic              pop_s;
    logic [BEAT_W:0]   rd_entry_s;

    r_state_t          r_state_r, r_state_s;
    logic [KW-1:0]     b_r, b_s;
    logic              rd_last_s;
    logic [DATA_W-1:0] asm_r, asm_s, out_data_r;
    logic              out_valid_r;

    // Writer handshake and current beat
    always_comb begin
        last_beat_s = (w_state_r == W_SPLIT) && (k_r == K_LAST);
        in_ready_s  = !rst && (credits_r >= C_LANES) && ((w_state_r == W_IDLE) || last_beat_s);
        accept_s    = in_valid && in_ready_s;
        wr_en_s     = (w_state_r == W_SPLIT);
        link_beat_s = map_beat(word_r, mode_r, int'(k_r));
    end

    // Writer next state; a word accepted on the last beat starts splitting immediately
    always_comb begin
        w_state_s = w_state_r;
        k_s       = k_r;
        case (w_state_r)
            W_IDLE: begin
                if (accept_s) begin
                    w_state_s = W_SPLIT;
                    k_s       = K_ZERO;
                end else begin
                    w_state_s = W_IDLE;
                end
            end
            W_SPLIT: begin
                if (last_beat_s) begin
                    w_state_s = accept_s ? W_SPLIT : W_IDLE;
                    k_s       = K_ZERO;
                end else begin
                    k_s = k_r + KW'(1'b1);
                end
            end
            default: begin
                w_state_s = W_IDLE;
                k_s       = K_ZERO;
            end
        endcase
    end

    // Writer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_r <= W_IDLE;
            k_r       <= K_ZERO;
        end else begin
            w_state_r <= w_state_s;
            k_r       <= k_s;
        end
    end

    // Accepted word and its lane mode
    always_ff @(posedge clk) begin
        if (accept_s) begin
            word_r <= in_data;
            mode_r <= in_mode;
        end
    end

    generate
        if (CREDIT_LAT == 0) begin : g_ret_direct
            assign ret_s = pop_s;
        end else begin : g_ret_pipe
            logic [CREDIT_LAT-1:0] cpipe_r;
            // Credit return delay line, one bit per pop
            always_ff @(posedge clk) begin
                if (rst) begin
                    cpipe_r <= {CREDIT_LAT{1'b0}};
                end else begin
                    cpipe_r[0] <= pop_s;
                    for (int i = 1; i < CREDIT_LAT; i++) begin
                        cpipe_r[i] <= cpipe_r[i-1];
                    end
                end
            end
            assign ret_s = cpipe_r[CREDIT_LAT-1];
        end
    endgenerate

    // Net credit update: reservation of a whole word and single-beat returns
    always_comb begin
        credits_s = credits_r;
        if (accept_s) begin
            credits_s = credits_s - C_LANES;
        end else begin
            credits_s = credits_s;
        end
        if (ret_s) begin
            credits_s = credits_s + CW'(1'b1);
        end else begin
            credits_s = credits_s;
        end
    end

    // Credit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            credits_r <= CW'(DEPTH);
        end else begin
            credits_r <= credits_s;
        end
    end

    // FIFO occupancy and read side
    always_comb begin
        count_s    = wptr_r - rptr_r;
        rd_entry_s = mem_r[rptr_r[AW-1:0]];
        pop_s      = (r_state_r == R_COLLECT) && (count_s != {(AW+1){1'b0}});
        rd_last_s  = (b_r == K_LAST);
    end

    // FIFO pointers; extra MSB distinguishes full from empty
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_r <= {(AW+1){1'b0}};
            rptr_r <= {(AW+1){1'b0}};
        end else begin
            if (wr_en_s) begin
                wptr_r <= wptr_r + (AW+1)'(1'b1);
            end
            if (pop_s) begin
                rptr_r <= rptr_r + (AW+1)'(1'b1);
            end
        end
    end

    // FIFO storage; each entry carries its beat's mode bit
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wptr_r[AW-1:0]] <= {mode_r, link_beat_s};
        end
    end

    // Reader next state and reassembly
    always_comb begin
        r_state_s = r_state_r;
        b_s       = b_r;
        asm_s     = place_beat(asm_r, rd_entry_s[BEAT_W-1:0], rd_entry_s[BEAT_W], int'(b_r));
        case (r_state_r)
            R_COLLECT: begin
                if (pop_s && rd_last_s) begin
                    r_state_s = R_HOLD;
                    b_s       = K_ZERO;
                end else if (pop_s) begin
                    b_s = b_r + KW'(1'b1);
                end else begin
                    b_s = b_r;
                end
            end
            R_HOLD: begin
                if (out_ready) begin
                    r_state_s = R_COLLECT;
                end else begin
                    r_state_s = R_HOLD;
                end
            end
            default: begin
                r_state_s = R_COLLECT;
                b_s       = K_ZERO;
            end
        endcase
    end

    // Reader state register; out_valid mirrors the hold state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_r   <= R_COLLECT;
            b_r         <= K_ZERO;
            out_valid_r <= 1'b0;
        end else begin
            r_state_r   <= r_state_s;
            b_r         <= b_s;
            out_valid_r <= (r_state_s == R_HOLD);
        end
    end

    // Reassembly buffer and output word
    always_ff @(posedge clk) begin
        if (pop_s) begin
            asm_r <= asm_s;
            if (rd_last_s) begin
                out_data_r <= asm_s;
            end
        end
    end

    assign in_ready   = in_ready_s;
    assign out_data   = out_data_r;
    assign out_valid  = out_valid_r;
    assign link_beat  = link_beat_s;
    assign link_valid = !rst && wr_en_s;
    assign credits    = credits_r;
    assign fifo_count = CW'(count_s);

    offchip_lane_link_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en_s),
        .pop        (pop_s),
        .fifo_count (fifo_count),
        .credits    (credits_r)
    );
endmodule

// File: tb/tb_offchip_lane_link.sv
// Bench for offchip_lane_link: directed flow-control/reset steps on a 2-lane link and a
// randomized lossless run on a 4-lane link, both checked against a queue-based model.
module tb_offchip_lane_link;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 2-lane link, CREDIT_LAT=2
    logic [63:0] a_in_data = 64'd0, a_out_data;
    logic        a_in_mode = 1'b0, a_in_valid = 1'b0, a_in_ready;
    logic        a_out_valid, a_out_ready = 1'b0, a_link_valid;
    logic [31:0] a_link_beat;
    logic [3:0]  a_credits, a_fifo_count;

    // 4-lane link, CREDIT_LAT=0
    logic [63:0] b_in_data = 64'd0, b_out_data;
    logic        b_in_mode = 1'b0, b_in_valid = 1'b0, b_in_ready;
    logic        b_out_valid, b_out_ready = 1'b0, b_link_valid;
    logic [15:0] b_link_beat;
    logic [3:0]  b_credits, b_fifo_count;

    offchip_lane_link #(.DATA_W(64), .LANES(2), .DEPTH(8), .CREDIT_LAT(2)) dut_a (
        .clk(clk), .rst(rst), .in_data(a_in_data), .in_mode(a_in_mode), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .out_data(a_out_data), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .link_beat(a_link_beat), .link_valid(a_link_valid),
        .credits(a_credits), .fifo_count(a_fifo_count));

    offchip_lane_link #(.DATA_W(64), .LANES(4), .DEPTH(8), .CREDIT_LAT(0)) dut_b (
        .clk(clk), .rst(rst), .in_data(b_in_data), .in_mode(b_in_mode), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .out_data(b_out_data), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .link_beat(b_link_beat), .link_valid(b_link_valid),
        .credits(b_credits), .fifo_count(b_fifo_count));

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] sq[$];
    logic [63:0] bq[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Expected beat k of a word, straight from the byte-placement rule
    function automatic logic [63:0] beat_of(input logic [63:0] w, input logic mode,
                                            input int lanes, input int k);
        logic [63:0] r;
        int bb, src;
        r  = 64'd0;
        bb = 8 / lanes;
        for (int j = 0; j < bb; j++) begin
            src = mode ? (j * lanes + k) : (k * bb + j);
            r[8*j +: 8] = w[8*src +: 8];
        end
        return r;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic single_word(input string tag, input logic mode,
                               input logic [63:0] w, input logic [63:0] e0, input logic [63:0] e1);
        a_in_data = w; a_in_mode = mode; a_in_valid = 1'b1; a_out_ready = 1'b1;
        chk({tag, "_in_ready"}, a_in_ready, 1);
        tick();
        a_in_valid = 1'b0;
        chk({tag, "_lv0"}, a_link_valid, 1);
        chk({tag, "_beat0"}, a_link_beat, e0);
        chk({tag, "_cred_res"}, a_credits, 6);
        tick();
        chk({tag, "_beat1"}, a_link_beat, e1);
        chk({tag, "_cnt1"}, a_fifo_count, 1);
        tick();
        chk({tag, "_lv_off"}, a_link_valid, 0);
        chk({tag, "_ov_early"}, a_out_valid, 0);
        tick();
        chk({tag, "_ov"}, a_out_valid, 1);
        chk({tag, "_data"}, a_out_data, w);
        chk({tag, "_cred_pend"}, a_credits, 6);
        tick();
        chk({tag, "_ov_drop"}, a_out_valid, 0);
        chk({tag, "_cred_ret1"}, a_credits, 7);
        tick();
        chk({tag, "_cred_ret2"}, a_credits, 8);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n_acc, rcvd, sent, cyc, last_acc, min_gap, bad_gap, first_acc, ov_seen;
        bit pending;

        // Reset state
        tick(); tick();
        chk("rst_in_ready", a_in_ready, 0);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_link_valid", a_link_valid, 0);
        chk("rst_credits", a_credits, 8);
        chk("rst_fifo_count", a_fifo_count, 0);
        rst = 1'b0;
        tick();

        // Pass and interleave mappings of the same word
        single_word("t1", 1'b0, 64'h0706050403020100, 64'h03020100, 64'h07060504);
        single_word("t2", 1'b1, 64'h0706050403020100, 64'h06040200, 64'h07050301);

        // Stalled consumer: credits limit the writer to five words
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = rand64(); a_in_mode = 1'($urandom_range(0, 1));
        n_acc = 0; pending = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (pending) begin
                a_in_data = rand64(); a_in_mode = 1'($urandom_range(0, 1)); pending = 1'b0;
            end
            if (a_in_valid && a_in_ready) begin
                sq.push_back(a_in_data); n_acc++; pending = 1'b1;
            end
            tick();
        end
        chk("t3_accepted", n_acc, 5);
        chk("t3_in_ready", a_in_ready, 0);
        chk("t3_credits", a_credits, 0);
        chk("t3_fifo_count", a_fifo_count, 8);
        chk("t3_out_valid", a_out_valid, 1);

        // One consumer pulse frees one word; credits come back CREDIT_LAT after each pop
        a_in_valid = 1'b0;
        chk("t4_word0", a_out_data, sq.pop_front());
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        chk("t4_ov_clear", a_out_valid, 0);
        tick();
        chk("t4_cred_pop1", a_credits, 0);
        tick();
        chk("t4_ov_next", a_out_valid, 1);
        chk("t4_word1", a_out_data, sq[0]);
        chk("t4_fifo", a_fifo_count, 6);
        chk("t4_ir_pop2", a_in_ready, 0);
        tick();
        chk("t4_cred_ret1", a_credits, 1);
        chk("t4_ir_ret1", a_in_ready, 0);
        tick();
        chk("t4_cred_ret2", a_credits, 2);
        chk("t4_ir_ret2", a_in_ready, 1);
        a_out_ready = 1'b1;
        for (int c = 0; c < 60 && sq.size() > 0; c++) begin
            if (a_out_valid) chk("t4_order", a_out_data, sq.pop_front());
            tick();
        end
        chk("t4_drained", sq.size(), 0);
        repeat (4) tick();
        chk("t4_cred_full", a_credits, 8);
        chk("t4_fifo_empty", a_fifo_count, 0);

        // Reset while the second beat is pending
        a_in_data = rand64(); a_in_mode = 1'b0; a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        chk("t5_lv", a_link_valid, 1);
        tick();
        chk("t5_cnt", a_fifo_count, 1);
        rst = 1'b1;
        tick();
        chk("t5_ov", a_out_valid, 0);
        chk("t5_credits", a_credits, 8);
        chk("t5_fifo", a_fifo_count, 0);
        chk("t5_in_ready", a_in_ready, 0);
        chk("t5_lv_rst", a_link_valid, 0);
        rst = 1'b0;
        ov_seen = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (a_out_valid) ov_seen++;
        end
        chk("t5_no_output", ov_seen, 0);
        chk("t5_fifo_after", a_fifo_count, 0);

        // 100 random words through the 4-lane link
        b_out_ready = 1'b1; b_in_valid = 1'b1; b_in_data = rand64(); b_in_mode = 1'($urandom_range(0, 1));
        rcvd = 0; sent = 0; cyc = 0; last_acc = -1; first_acc = 0; min_gap = 1000; bad_gap = 0;
        pending = 1'b0;
        while (rcvd < 100 && cyc < 3000) begin
            if (b_link_valid) begin
                if (bq.size() > 0) chk("t6_link", b_link_beat, bq.pop_front());
                else chk("t6_link_extra", b_link_valid, 0);
            end
            if (b_out_valid) begin
                if (sq.size() > 0) chk("t6_data", b_out_data, sq.pop_front());
                else chk("t6_out_extra", b_out_valid, 0);
                rcvd++;
            end
            if (pending) begin
                pending = 1'b0;
                if (sent < 100) begin
                    b_in_data = rand64(); b_in_mode = 1'($urandom_range(0, 1));
                end else begin
                    b_in_valid = 1'b0;
                end
            end
            if (b_in_valid && b_in_ready) begin
                sq.push_back(b_in_data);
                for (int k = 0; k < 4; k++) bq.push_back(beat_of(b_in_data, b_in_mode, 4, k));
                if (last_acc >= 0) begin
                    if (cyc - last_acc < 4) bad_gap++;
                    if (cyc - last_acc < min_gap) min_gap = cyc - last_acc;
                end else begin
                    first_acc = cyc;
                end
                last_acc = cyc; sent++; pending = 1'b1;
            end
            tick();
            cyc++;
        end
        chk("t6_received", rcvd, 100);
        chk("t6_sent", sent, 100);
        chk("t6_leftover", sq.size(), 0);
        chk("t6_gap_violations", bad_gap, 0);
        chk("t6_min_gap", min_gap, 4);
        // Each word costs four pops plus one hold cycle at the reader
        chk("t6_rate", (cyc - first_acc) <= 100 * 5 + 20, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
